// File: rtl/issue_unit_pkg.sv
// Shared definitions for the in-order issue stage: opcode constants, instruction field
// positions, FSM state encoding and small helpers.
package issue_unit_pkg;

  localparam int unsigned UNIT_W = 3;

  localparam logic [UNIT_W-1:0] UNIT_LW   = 3'b000;
  localparam logic [UNIT_W-1:0] UNIT_SW   = 3'b001;
  localparam logic [UNIT_W-1:0] UNIT_ADD  = 3'b010;
  localparam logic [UNIT_W-1:0] UNIT_MUL  = 3'b011;
  localparam logic [UNIT_W-1:0] UNIT_MV   = 3'b100;
  localparam logic [UNIT_W-1:0] UNIT_HALT = 3'b101;

  // Field positions inside the 64-bit decoded instruction word.
  localparam int unsigned INSTR_W    = 64;
  localparam int unsigned UNIT_LSB   = 61;
  localparam int unsigned HASIMM_BIT = 60;
  localparam int unsigned R1_LSB     = 54;
  localparam int unsigned R2_LSB     = 48;
  localparam int unsigned R3_LSB     = 42;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StBackoff
  } issue_state_e;

  // Units 110/111 have no reservation station and are dropped.
  function automatic logic unit_is_legal(input logic [UNIT_W-1:0] unit);
    case (unit)
      UNIT_LW, UNIT_SW, UNIT_ADD, UNIT_MUL, UNIT_MV, UNIT_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous show-ahead FIFO holding decoded instruction words ahead of the issue FSM.
module issue_fifo
  import issue_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are only meaningful while count_q covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/issue_unit.sv
// In-order issue stage: buffers fetched instructions, offers them one at a time to the
// reservation stations, backs off and retries when a station is full, and stops at halt.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REG_W      = 6,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned BACKOFF    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [63:0]        in_instr,
  output logic               in_ready,
  output logic               rs_en,
  output logic [2:0]         rs_unit,
  output logic [REG_W-1:0]   rs_reg1,
  output logic [REG_W-1:0]   rs_reg2,
  output logic [REG_W-1:0]   rs_reg3,
  output logic               rs_hasimm,
  output logic [WORD_W-1:0]  rs_imm,
  input  logic               rs_ack,
  input  logic               rs_ok,
  output logic               halted,
  output logic               illegal,
  output logic [31:0]        issue_cnt,
  output logic [31:0]        stall_cnt
);

  localparam int unsigned BoW = $clog2(BACKOFF + 1);

  issue_state_e       state_q;
  logic               rs_en_q, rs_hasimm_q, halted_q, illegal_q;
  logic [UNIT_W-1:0]  rs_unit_q;
  logic [REG_W-1:0]   rs_reg1_q, rs_reg2_q, rs_reg3_q;
  logic [WORD_W-1:0]  rs_imm_q;
  logic [BoW-1:0]     bo_cnt_q;
  logic [31:0]        issue_cnt_q, stall_cnt_q;

  logic [INSTR_W-1:0] head;
  logic               fifo_empty, fifo_full, push, pop;
  logic               unused_head;

  // Reserved bits of the instruction word are carried but never decoded.
  assign unused_head = ^head[R3_LSB-1:WORD_W];

  // Hold off fetch while in reset, when full, or once halted.
  assign in_ready = rst_n && !fifo_full && !halted_q;
  assign push     = in_valid && in_ready;

  // Head leaves only when dropped as illegal or accepted by the RS.
  assign pop = ((state_q == StIssue) && !unit_is_legal(rs_unit_q)) ||
               ((state_q == StWait) && rs_ack && rs_ok);

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_instr),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Issue FSM with registered RS request, back-off counter and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rs_en_q     <= 1'b0;
      rs_unit_q   <= '0;
      rs_reg1_q   <= '0;
      rs_reg2_q   <= '0;
      rs_reg3_q   <= '0;
      rs_hasimm_q <= 1'b0;
      rs_imm_q    <= '0;
      bo_cnt_q    <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      rs_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty && !halted_q) begin
            state_q     <= StIssue;
            // Request pulse coincides with the ISSUE cycle; illegal heads never pulse.
            rs_en_q     <= unit_is_legal(head[UNIT_LSB +: UNIT_W]);
            rs_unit_q   <= head[UNIT_LSB +: UNIT_W];
            rs_hasimm_q <= head[HASIMM_BIT];
            rs_reg1_q   <= head[R1_LSB +: REG_W];
            rs_reg2_q   <= head[R2_LSB +: REG_W];
            rs_reg3_q   <= head[R3_LSB +: REG_W];
            rs_imm_q    <= head[IMM_LSB +: WORD_W];
          end
        end
        StIssue: begin
          if (unit_is_legal(rs_unit_q)) begin
            state_q <= StWait;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StWait: begin
          if (rs_ack) begin
            if (rs_ok) begin
              issue_cnt_q <= sat_inc(issue_cnt_q);
              if (rs_unit_q == UNIT_HALT) halted_q <= 1'b1;
              state_q <= StIdle;
            end else begin
              bo_cnt_q <= BoW'(BACKOFF);
              state_q  <= StBackoff;
            end
          end
        end
        StBackoff: begin
          stall_cnt_q <= sat_inc(stall_cnt_q);
          bo_cnt_q    <= bo_cnt_q - 1'b1;
          // Last idle cycle: re-offer the same entry, fields are still held.
          if (bo_cnt_q == BoW'(1)) begin
            rs_en_q <= 1'b1;
            state_q <= StIssue;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rs_en     = rs_en_q;
  assign rs_unit   = rs_unit_q;
  assign rs_reg1   = rs_reg1_q;
  assign rs_reg2   = rs_reg2_q;
  assign rs_reg3   = rs_reg3_q;
  assign rs_hasimm = rs_hasimm_q;
  assign rs_imm    = rs_imm_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule
